// File: rtl/operand_fetch_pkg.sv
// -----------------------------------------------------------------------------
// operand_fetch_pkg
//   Shared widths, types and FSM encoding for the operand fetch stage and its
//   pending-write scoreboard.
//   Contents: DATA_W, ADDR_W, NREGS; reg_addr_t, data_t; of_state_t;
//             reg_onehot() helper (address -> one-hot register mask).
// -----------------------------------------------------------------------------
package operand_fetch_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 2;
  localparam int NREGS  = 2 ** ADDR_W;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [NREGS-1:0]  reg_mask_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    VALID = 2'd2
  } of_state_t;

  function automatic reg_mask_t reg_onehot(input reg_addr_t addr);
    reg_mask_t mask;
    mask       = '0;
    mask[addr] = 1'b1;
    return mask;
  endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// -----------------------------------------------------------------------------
// operand_fetch_if
//   Bundles the issue, register-file, operand and writeback buses of the
//   operand fetch stage.
//   slave  : the operand_fetch side (consumes iss_*, rf_data_out_*, op_ready,
//            wb_*; drives iss_ready, rf_* requests, op_*).
//   master : the surrounding pipeline / register file / bench side.
// -----------------------------------------------------------------------------
interface operand_fetch_if;
  import operand_fetch_pkg::*;

  // Issue handshake
  logic      iss_valid;
  logic      iss_ready;
  reg_addr_t iss_src_a;
  reg_addr_t iss_src_b;
  logic      iss_use_a;
  logic      iss_use_b;
  reg_addr_t iss_dst;
  logic      iss_wr;

  // Register file read ports (registered read data)
  logic      rf_read_en_A;
  logic      rf_read_en_B;
  reg_addr_t rf_addr_read_A;
  reg_addr_t rf_addr_read_B;
  data_t     rf_data_out_A;
  data_t     rf_data_out_B;

  // Register file write port
  logic      rf_write_en;
  reg_addr_t rf_addr_write;
  data_t     rf_data_in;

  // Downstream operand handshake
  logic      op_valid;
  logic      op_ready;
  data_t     op_a;
  data_t     op_b;
  reg_addr_t op_dst;
  logic      op_wr;

  // Writeback strobe (always accepted)
  logic      wb_valid;
  reg_addr_t wb_addr;
  data_t     wb_data;

  modport slave (
    input  iss_valid, iss_src_a, iss_src_b, iss_use_a, iss_use_b, iss_dst, iss_wr,
    output iss_ready,
    output rf_read_en_A, rf_read_en_B, rf_addr_read_A, rf_addr_read_B,
    input  rf_data_out_A, rf_data_out_B,
    output rf_write_en, rf_addr_write, rf_data_in,
    output op_valid, op_a, op_b, op_dst, op_wr,
    input  op_ready,
    input  wb_valid, wb_addr, wb_data
  );

  modport master (
    output iss_valid, iss_src_a, iss_src_b, iss_use_a, iss_use_b, iss_dst, iss_wr,
    input  iss_ready,
    input  rf_read_en_A, rf_read_en_B, rf_addr_read_A, rf_addr_read_B,
    output rf_data_out_A, rf_data_out_B,
    input  rf_write_en, rf_addr_write, rf_data_in,
    input  op_valid, op_a, op_b, op_dst, op_wr,
    output op_ready,
    output wb_valid, wb_addr, wb_data
  );

endinterface

// File: rtl/operand_fetch_op_scoreboard.sv
// -----------------------------------------------------------------------------
// op_scoreboard
//   Pending-write vector for the 4-entry register file. A bit is set when an
//   instruction that writes that register is accepted and cleared by its
//   writeback. A writeback landing this cycle already counts as ready.
//   Ports:
//     clk, sync_rst_n          clock, synchronous active-low reset
//     i_set, i_set_addr        mark i_set_addr pending (issue accepted, wr=1)
//     i_wb_valid, i_wb_addr    writeback bus (clears pending)
//     i_src_a/b, i_use_a/b     sources of the offered instruction
//     i_dst, i_wr              destination of the offered instruction
//     o_src_a_ok, o_src_b_ok   source has no outstanding write
//     o_dst_ok                 destination has no outstanding write (WAW)
// -----------------------------------------------------------------------------
module op_scoreboard
  import operand_fetch_pkg::*;
(
  input  logic      clk,
  input  logic      sync_rst_n,
  input  logic      i_set,
  input  reg_addr_t i_set_addr,
  input  logic      i_wb_valid,
  input  reg_addr_t i_wb_addr,
  input  reg_addr_t i_src_a,
  input  reg_addr_t i_src_b,
  input  logic      i_use_a,
  input  logic      i_use_b,
  input  reg_addr_t i_dst,
  input  logic      i_wr,
  output logic      o_src_a_ok,
  output logic      o_src_b_ok,
  output logic      o_dst_ok
);

  reg_mask_t r_pending;
  reg_mask_t w_wb_hit;
  reg_mask_t w_set;

  assign w_wb_hit = i_wb_valid ? reg_onehot(i_wb_addr)  : '0;
  assign w_set    = i_set      ? reg_onehot(i_set_addr) : '0;

  // NOTE: reset is synchronous -- sync_rst_n is only looked at on the clock
  // edge, so it is not in the sensitivity list.
  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      r_pending <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values, independent of statement order.
      // Clear first, then OR in the set: a new writer issued in the same
      // cycle as the old writer's writeback keeps the register pending.
      r_pending <= (r_pending & ~w_wb_hit) | w_set;
    end
  end

  assign o_src_a_ok = !i_use_a || !r_pending[i_src_a] || w_wb_hit[i_src_a];
  assign o_src_b_ok = !i_use_b || !r_pending[i_src_b] || w_wb_hit[i_src_b];
  assign o_dst_ok   = !i_wr    || !r_pending[i_dst]   || w_wb_hit[i_dst];

endmodule

// File: rtl/operand_fetch.sv
// -----------------------------------------------------------------------------
// operand_fetch
//   Requester side of the 4x8 register file. Accepts decoded instructions,
//   reads their sources through the registered-read ports, and presents the
//   operands downstream two cycles after acceptance. Also owns the register
//   file write port, which is a straight pass-through of the writeback bus.
//   Ports:
//     clk          clock
//     sync_rst_n   synchronous active-low reset
//     bus          operand_fetch_if.slave (issue, rf read/write, operand, wb)
//   Timing: accept in cycle T -> READ in T+1 -> op_valid from T+2.
// -----------------------------------------------------------------------------
module operand_fetch
  import operand_fetch_pkg::*;
(
  input  logic            clk,
  input  logic            sync_rst_n,
  operand_fetch_if.slave  bus
);

  of_state_t r_state;
  of_state_t w_state_nxt;

  logic      w_src_a_ok;
  logic      w_src_b_ok;
  logic      w_dst_ok;
  logic      w_slot_free;
  logic      w_iss_ready;
  logic      w_accept;

  // Instruction captured at acceptance, consumed in READ
  reg_addr_t r_dst;
  logic      r_wr;
  logic      r_use_a;
  logic      r_use_b;
  logic      r_byp_a;
  logic      r_byp_b;
  data_t     r_wb_data;

  // Operand outputs
  data_t     r_op_a;
  data_t     r_op_b;
  reg_addr_t r_op_dst;
  logic      r_op_wr;

  // ---------------------------------------------------------------------------
  // Hazard check and issue handshake
  // ---------------------------------------------------------------------------
  op_scoreboard u_sb (
    .clk        (clk),
    .sync_rst_n (sync_rst_n),
    .i_set      (w_accept && bus.iss_wr),
    .i_set_addr (bus.iss_dst),
    .i_wb_valid (bus.wb_valid),
    .i_wb_addr  (bus.wb_addr),
    .i_src_a    (bus.iss_src_a),
    .i_src_b    (bus.iss_src_b),
    .i_use_a    (bus.iss_use_a),
    .i_use_b    (bus.iss_use_b),
    .i_dst      (bus.iss_dst),
    .i_wr       (bus.iss_wr),
    .o_src_a_ok (w_src_a_ok),
    .o_src_b_ok (w_src_b_ok),
    .o_dst_ok   (w_dst_ok)
  );

  // A new instruction may enter when the stage is empty or its current
  // operands leave this cycle.
  assign w_slot_free = (r_state == IDLE) || ((r_state == VALID) && bus.op_ready);
  // Gated by reset so nothing is accepted into a stage that is being cleared.
  assign w_iss_ready = sync_rst_n && w_src_a_ok && w_src_b_ok && w_dst_ok && w_slot_free;
  assign w_accept    = bus.iss_valid && w_iss_ready;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!sync_rst_n) r_state <= IDLE;
    else             r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: default first so every path assigns w_state_nxt; no latch.
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_accept) w_state_nxt = READ;
      READ:    w_state_nxt = VALID;
      VALID:   if (bus.op_ready) w_state_nxt = w_accept ? READ : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Issue capture
  // ---------------------------------------------------------------------------
  // The register file returns the pre-write value when a read and a write to
  // the same register share an edge, so a writeback coinciding with the
  // accept is remembered here and substituted in READ.
  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      r_dst     <= '0;
      r_wr      <= 1'b0;
      r_use_a   <= 1'b0;
      r_use_b   <= 1'b0;
      r_byp_a   <= 1'b0;
      r_byp_b   <= 1'b0;
      r_wb_data <= '0;
    end else if (w_accept) begin
      r_dst     <= bus.iss_dst;
      r_wr      <= bus.iss_wr;
      r_use_a   <= bus.iss_use_a;
      r_use_b   <= bus.iss_use_b;
      r_byp_a   <= bus.iss_use_a && bus.wb_valid && (bus.wb_addr == bus.iss_src_a);
      r_byp_b   <= bus.iss_use_b && bus.wb_valid && (bus.wb_addr == bus.iss_src_b);
      r_wb_data <= bus.wb_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Operand capture at the end of READ; held through VALID backpressure.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!sync_rst_n) begin
      r_op_a   <= '0;
      r_op_b   <= '0;
      r_op_dst <= '0;
      r_op_wr  <= 1'b0;
    end else if (r_state == READ) begin
      r_op_a   <= r_byp_a ? r_wb_data : (r_use_a ? bus.rf_data_out_A : '0);
      r_op_b   <= r_byp_b ? r_wb_data : (r_use_b ? bus.rf_data_out_B : '0);
      r_op_dst <= r_dst;
      r_op_wr  <= r_wr;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.iss_ready      = w_iss_ready;

  // Reads are issued only in the accept cycle.
  assign bus.rf_read_en_A   = w_accept && bus.iss_use_a;
  assign bus.rf_read_en_B   = w_accept && bus.iss_use_b;
  assign bus.rf_addr_read_A = w_accept ? bus.iss_src_a : '0;
  assign bus.rf_addr_read_B = w_accept ? bus.iss_src_b : '0;

  assign bus.rf_write_en    = sync_rst_n && bus.wb_valid;
  assign bus.rf_addr_write  = sync_rst_n ? bus.wb_addr : '0;
  assign bus.rf_data_in     = sync_rst_n ? bus.wb_data : '0;

  assign bus.op_valid       = (r_state == VALID);
  assign bus.op_a           = r_op_a;
  assign bus.op_b           = r_op_b;
  assign bus.op_dst         = r_op_dst;
  assign bus.op_wr          = r_op_wr;

endmodule

// File: tb/tb_operand_fetch.sv
// -----------------------------------------------------------------------------
// tb_operand_fetch
//   Directed bench for operand_fetch. A behavioural 4x8 register file with
//   registered reads (pre-write value on a same-edge collision) sits on the
//   rf_* ports. Simple issues come from a vector table; hazards, backpressure
//   and mid-operation reset are hand-written sequences.
//   Inputs are driven 1 time unit after posedge; outputs are checked 2 units
//   after posedge.
// -----------------------------------------------------------------------------
module tb_operand_fetch;
  import operand_fetch_pkg::*;

  logic clk;
  logic sync_rst_n;

  operand_fetch_if bus ();

  operand_fetch dut (
    .clk        (clk),
    .sync_rst_n (sync_rst_n),
    .bus        (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file environment
  logic [7:0] rf_mem [4] = '{default: 8'h00};

  always @(posedge clk) begin
    if (bus.rf_read_en_A) bus.rf_data_out_A <= rf_mem[bus.rf_addr_read_A];
    if (bus.rf_read_en_B) bus.rf_data_out_B <= rf_mem[bus.rf_addr_read_B];
    if (bus.rf_write_en)  rf_mem[bus.rf_addr_write] <= bus.rf_data_in;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] src_a, input logic [1:0] src_b,
                       input logic use_a, input logic use_b,
                       input logic [1:0] dst, input logic wr);
    bus.iss_valid = 1'b1;
    bus.iss_src_a = src_a;
    bus.iss_src_b = src_b;
    bus.iss_use_a = use_a;
    bus.iss_use_b = use_b;
    bus.iss_dst   = dst;
    bus.iss_wr    = wr;
  endtask

  task automatic wb(input logic v, input logic [1:0] addr, input logic [7:0] data);
    bus.wb_valid = v;
    bus.wb_addr  = addr;
    bus.wb_data  = data;
  endtask

  typedef struct {
    logic [1:0] src_a;
    logic [1:0] src_b;
    logic       use_a;
    logic       use_b;
    logic [1:0] dst;
    logic [7:0] exp_a;
    logic [7:0] exp_b;
  } vec_t;

  vec_t       vecs [5];
  logic [7:0] pre  [4];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    pre[0] = 8'hA0; pre[1] = 8'h11; pre[2] = 8'h22; pre[3] = 8'h33;

    vecs[0] = '{2'd1, 2'd2, 1'b1, 1'b1, 2'd0, 8'h11, 8'h22};
    vecs[1] = '{2'd3, 2'd0, 1'b1, 1'b1, 2'd1, 8'h33, 8'hA0};
    vecs[2] = '{2'd2, 2'd2, 1'b1, 1'b1, 2'd3, 8'h22, 8'h22};
    vecs[3] = '{2'd1, 2'd3, 1'b0, 1'b0, 2'd2, 8'h00, 8'h00};
    vecs[4] = '{2'd0, 2'd1, 1'b1, 1'b0, 2'd1, 8'hA0, 8'h00};

    // ---------------- Reset with activity on the inputs ----------------
    sync_rst_n   = 1'b0;
    bus.op_ready = 1'b0;
    issue(2'd1, 2'd2, 1'b1, 1'b1, 2'd3, 1'b1);
    wb(1'b1, 2'd2, 8'h99);
    tick();
    tick();
    #1;
    check("rst_op_valid",   8'(bus.op_valid),       8'd0);
    check("rst_op_a",       bus.op_a,               8'h00);
    check("rst_op_dst",     8'(bus.op_dst),         8'd0);
    check("rst_rd_en_a",    8'(bus.rf_read_en_A),   8'd0);
    check("rst_rd_en_b",    8'(bus.rf_read_en_B),   8'd0);
    check("rst_rd_addr_a",  8'(bus.rf_addr_read_A), 8'd0);
    check("rst_wr_en",      8'(bus.rf_write_en),    8'd0);
    check("rst_wr_addr",    8'(bus.rf_addr_write),  8'd0);
    check("rst_wr_data",    bus.rf_data_in,         8'h00);
    sync_rst_n    = 1'b1;
    bus.iss_valid = 1'b0;
    wb(1'b0, 2'd0, 8'h00);
    #1;
    check("post_rst_iss_ready", 8'(bus.iss_ready), 8'd1);

    // ---------------- Preload registers via writeback ----------------
    for (int i = 0; i < 4; i++) begin
      tick();
      wb(1'b1, 2'(i), pre[i]);
      #1;
      check("wb_pass_en",   8'(bus.rf_write_en),   8'd1);
      check("wb_pass_addr", 8'(bus.rf_addr_write), 8'(i));
      check("wb_pass_data", bus.rf_data_in,        pre[i]);
    end
    tick();
    wb(1'b0, 2'd0, 8'h00);

    // ---------------- Table-driven simple issues ----------------
    for (int v = 0; v < 5; v++) begin
      tick();
      issue(vecs[v].src_a, vecs[v].src_b, vecs[v].use_a, vecs[v].use_b, vecs[v].dst, 1'b0);
      #1;
      check("vec_iss_ready", 8'(bus.iss_ready),      8'd1);
      check("vec_rd_en_a",   8'(bus.rf_read_en_A),   8'(vecs[v].use_a));
      check("vec_rd_en_b",   8'(bus.rf_read_en_B),   8'(vecs[v].use_b));
      check("vec_rd_addr_a", 8'(bus.rf_addr_read_A), 8'(vecs[v].src_a));
      check("vec_rd_addr_b", 8'(bus.rf_addr_read_B), 8'(vecs[v].src_b));
      tick();
      bus.iss_valid = 1'b0;
      #1;
      check("vec_read_op_valid", 8'(bus.op_valid),     8'd0);
      check("vec_read_rd_en_a",  8'(bus.rf_read_en_A), 8'd0);
      check("vec_read_ready",    8'(bus.iss_ready),    8'd0);
      tick();
      #1;
      check("vec_op_valid", 8'(bus.op_valid), 8'd1);
      check("vec_op_a",     bus.op_a,         vecs[v].exp_a);
      check("vec_op_b",     bus.op_b,         vecs[v].exp_b);
      check("vec_op_dst",   8'(bus.op_dst),   8'(vecs[v].dst));
      check("vec_op_wr",    8'(bus.op_wr),    8'd0);
      bus.op_ready = 1'b1;
      tick();
      bus.op_ready = 1'b0;
      #1;
      check("vec_drain_op_valid", 8'(bus.op_valid), 8'd0);
    end

    // ---------------- RAW hazard with same-cycle bypass ----------------
    tick();
    issue(2'd0, 2'd0, 1'b0, 1'b0, 2'd3, 1'b1);
    #1;
    check("raw_w_ready", 8'(bus.iss_ready), 8'd1);
    tick();
    bus.iss_valid = 1'b0;
    tick();
    #1;
    check("raw_w_op_valid", 8'(bus.op_valid), 8'd1);
    check("raw_w_op_wr",    8'(bus.op_wr),    8'd1);
    check("raw_w_op_dst",   8'(bus.op_dst),   8'd3);
    bus.op_ready = 1'b1;
    tick();
    bus.op_ready = 1'b0;
    issue(2'd3, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0);
    #1;
    for (int i = 0; i < 3; i++) begin
      check("raw_stall_ready", 8'(bus.iss_ready),    8'd0);
      check("raw_stall_rd_en", 8'(bus.rf_read_en_A), 8'd0);
      tick();
      #1;
    end
    wb(1'b1, 2'd3, 8'h5A);
    #1;
    check("raw_wb_ready", 8'(bus.iss_ready),    8'd1);
    check("raw_wb_rd_en", 8'(bus.rf_read_en_A), 8'd1);
    tick();
    wb(1'b0, 2'd0, 8'h00);
    bus.iss_valid = 1'b0;
    tick();
    #1;
    check("raw_op_valid",  8'(bus.op_valid), 8'd1);
    check("raw_bypass_a",  bus.op_a,         8'h5A);
    bus.op_ready = 1'b1;
    tick();
    bus.op_ready = 1'b0;

    // ------- Writeback during READ is not reflected; r0 is not pending -------
    issue(2'd0, 2'd1, 1'b1, 1'b1, 2'd1, 1'b0);
    #1;
    check("rdwb_ready", 8'(bus.iss_ready), 8'd1);
    tick();
    bus.iss_valid = 1'b0;
    wb(1'b1, 2'd0, 8'hB0);
    tick();
    wb(1'b0, 2'd0, 8'h00);
    #1;
    check("rdwb_op_a_old", bus.op_a, 8'hA0);
    check("rdwb_op_b",     bus.op_b, 8'h11);
    bus.op_ready = 1'b1;
    tick();
    bus.op_ready = 1'b0;

    // ---------------- Backpressure and back-to-back accept ----------------
    issue(2'd1, 2'd2, 1'b1, 1'b1, 2'd1, 1'b0);
    tick();
    bus.iss_valid = 1'b0;
    tick();
    issue(2'd3, 2'd0, 1'b1, 1'b1, 2'd2, 1'b0);
    #1;
    for (int i = 0; i < 5; i++) begin
      check("bp_op_valid",  8'(bus.op_valid),  8'd1);
      check("bp_op_a",      bus.op_a,          8'h11);
      check("bp_op_b",      bus.op_b,          8'h22);
      check("bp_op_dst",    8'(bus.op_dst),    8'd1);
      check("bp_iss_ready", 8'(bus.iss_ready), 8'd0);
      tick();
      #1;
    end
    bus.op_ready = 1'b1;
    #1;
    check("b2b_iss_ready", 8'(bus.iss_ready),    8'd1);
    check("b2b_rd_en_a",   8'(bus.rf_read_en_A), 8'd1);
    tick();
    bus.iss_valid = 1'b0;
    bus.op_ready  = 1'b0;
    #1;
    check("b2b_read_op_valid", 8'(bus.op_valid), 8'd0);
    tick();
    #1;
    check("b2b_op_valid", 8'(bus.op_valid), 8'd1);
    check("b2b_op_a",     bus.op_a,         8'h5A);
    check("b2b_op_b",     bus.op_b,         8'hB0);
    check("b2b_op_dst",   8'(bus.op_dst),   8'd2);
    bus.op_ready = 1'b1;
    tick();
    bus.op_ready = 1'b0;

    // ---------------- WAW stall and set-wins ----------------
    issue(2'd0, 2'd0, 1'b0, 1'b0, 2'd2, 1'b1);
    #1;
    check("waw1_ready",   8'(bus.iss_ready),    8'd1);
    check("waw1_rd_en_a", 8'(bus.rf_read_en_A), 8'd0);
    check("waw1_rd_en_b", 8'(bus.rf_read_en_B), 8'd0);
    tick();
    bus.iss_valid = 1'b0;
    tick();
    #1;
    check("waw1_op_a",  bus.op_a,       8'h00);
    check("waw1_op_b",  bus.op_b,       8'h00);
    check("waw1_op_wr", 8'(bus.op_wr),  8'd1);
    bus.op_ready = 1'b1;
    tick();
    bus.op_ready = 1'b0;
    issue(2'd0, 2'd0, 1'b0, 1'b0, 2'd2, 1'b1);
    #1;
    check("waw2_stall", 8'(bus.iss_ready), 8'd0);
    tick();
    #1;
    check("waw2_stall", 8'(bus.iss_ready), 8'd0);
    wb(1'b1, 2'd2, 8'h77);
    #1;
    check("waw2_wb_ready", 8'(bus.iss_ready), 8'd1);
    tick();
    wb(1'b0, 2'd0, 8'h00);
    bus.iss_valid = 1'b0;
    tick();
    bus.op_ready = 1'b1;
    #1;
    check("waw2_op_valid", 8'(bus.op_valid), 8'd1);
    tick();
    bus.op_ready = 1'b0;
    issue(2'd2, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0);
    #1;
    check("set_wins_stall", 8'(bus.iss_ready), 8'd0);
    tick();
    wb(1'b1, 2'd2, 8'h78);
    #1;
    check("set_wins_wb_ready", 8'(bus.iss_ready), 8'd1);
    tick();
    wb(1'b0, 2'd0, 8'h00);
    bus.iss_valid = 1'b0;
    tick();
    #1;
    check("set_wins_op_a", bus.op_a, 8'h78);
    bus.op_ready = 1'b1;
    tick();
    bus.op_ready = 1'b0;

    // ---------------- Reset during READ ----------------
    issue(2'd1, 2'd0, 1'b1, 1'b0, 2'd1, 1'b1);
    #1;
    check("rstr_ready", 8'(bus.iss_ready), 8'd1);
    tick();
    bus.iss_valid = 1'b0;
    sync_rst_n    = 1'b0;
    wb(1'b1, 2'd0, 8'hFF);
    #1;
    check("rstr_wr_en",   8'(bus.rf_write_en), 8'd0);
    check("rstr_wr_data", bus.rf_data_in,      8'h00);
    tick();
    sync_rst_n = 1'b1;
    wb(1'b0, 2'd0, 8'h00);
    #1;
    check("rstr_op_valid", 8'(bus.op_valid), 8'd0);
    tick();
    #1;
    check("rstr_no_partial", 8'(bus.op_valid), 8'd0);
    issue(2'd1, 2'd0, 1'b1, 1'b0, 2'd0, 1'b0);
    #1;
    check("rstr_pending_clr", 8'(bus.iss_ready), 8'd1);
    tick();
    bus.iss_valid = 1'b0;
    tick();
    #1;
    check("rstr_op_a", bus.op_a, 8'h11);
    bus.op_ready = 1'b1;
    tick();
    bus.op_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Requester side of the 4x8 register file's read/write interface. Accepts decoded instructions over a valid/ready handshake.
- Drives the register file's read ports and captures the registered read data. Presents operands downstream over valid/ready.
- Owns the register file's single write port for writeback.
- A 4-bit pending-write scoreboard stalls read-after-write (RAW) and write-after-write (WAW) hazards. A same-cycle writeback bypass covers the register file's registered-read/write collision.

Parameters:
- DATA_W, 8, operand/register width.
- ADDR_W, 2, register address width; NREGS = 2**ADDR_W = 4.

Ports:
- clk  in  1  clock.
- sync_rst_n  in  1  synchronous reset, active-low.
- iss_valid  in  1  instruction offered.
- iss_ready  out  1  instruction accepted when iss_valid && iss_ready.
- iss_src_a, iss_src_b  in  ADDR_W  source register addresses.
- iss_use_a, iss_use_b  in  1  source actually used.
- iss_dst  in  ADDR_W  destination register.
- iss_wr  in  1  instruction will write iss_dst.
- rf_read_en_A, rf_read_en_B  out  1  register file read enables.
- rf_addr_read_A, rf_addr_read_B  out  ADDR_W  register file read addresses.
- rf_data_out_A, rf_data_out_B  in  DATA_W  registered register file read data.
- rf_write_en  out  1  register file write enable.
- rf_addr_write  out  ADDR_W  register file write address.
- rf_data_in  out  DATA_W  register file write data.
- op_valid  out  1  operands valid downstream.
- op_ready  in  1  downstream accepts.
- op_a, op_b  out  DATA_W  operand values.
- op_dst  out  ADDR_W  destination, forwarded with the operands.
- op_wr  out  1  write flag, forwarded with the operands.
- wb_valid  in  1  writeback strobe; no ready, always accepted.
- wb_addr  in  ADDR_W  writeback address.
- wb_data  in  DATA_W  writeback data.

Behaviour:
- Clock and reset: single clock clk. sync_rst_n is synchronous, active-low.
- Reset (sync_rst_n=0 at a posedge):
  - state=IDLE, pending=0.
  - op_valid, op_a, op_b, op_dst, op_wr, all rf_* outputs = 0.
  - iss_ready is combinational and reads 1 after reset.
  - Reset mid-operation discards the in-flight instruction; no partial op_valid.
- Writeback path is combinational pass-through: rf_write_en=wb_valid, rf_addr_write=wb_addr, rf_data_in=wb_data. Forced to 0 while sync_rst_n=0.
- Source ready: src_ok(s) = !pending[s] || (wb_valid && wb_addr==s). Unused sources are always ok.
- Destination ok: dst_ok = !iss_wr || !pending[iss_dst] || (wb_valid && wb_addr==iss_dst).
- iss_ready = src_ok(a) && src_ok(b) && dst_ok && (state==IDLE || (state==VALID && op_ready)).
- States: IDLE, READ, VALID.
  - IDLE: on accept -> READ.
  - READ: always lasts exactly 1 cycle -> VALID.
  - VALID: op_valid=1.
    - op_ready && accept -> READ (back-to-back).
    - op_ready && !accept -> IDLE.
    - !op_ready -> hold; op_* stable.
- Accept cycle T:
  - rf_read_en_X = iss_use_X; rf_addr_read_X = iss_src_X. Read enables are low in every other cycle.
  - Latch dst/wr and the use flags.
  - Bypass flag byp_X = use_X && wb_valid && wb_addr==src_X; also latch wb_data.
  - Reason for the bypass: the register file returns the pre-write value on a same-edge collision.
- READ cycle (T+1): at the end of T+1 capture into op_X:
  - byp_X ? latched wb_data : (use_X ? rf_data_out_X : 0).
  - A writeback during READ to a source register is not reflected; operand values are those at issue.
- Latency: op_valid asserts in cycle T+2. Maximum throughput is one instruction per 2 cycles.
- Scoreboard:
  - pending[iss_dst] is set on accept when iss_wr=1.
  - pending[wb_addr] is cleared on wb_valid.
  - Same bit set and cleared in the same cycle: set wins.
  - wb_valid to a non-pending register is still written; the scoreboard is unchanged.

Decomposition:
- Shared package (alongside the existing cpu typedefs): DATA_W, ADDR_W, NREGS; typedef reg_addr_t, data_t; enum of_state_t {IDLE, READ, VALID}.
- One sub-module: op_scoreboard. Holds the pending vector and the set/clear priority. Outputs src_ok/dst_ok given addresses and the writeback bus.

Test Plan:
1. Reset: hold sync_rst_n=0 for 2 cycles -> op_valid=0, all rf_* outputs 0, pending=0; iss_ready=1 after release.
2. Preload r1=0x11, r2=0x22 via wb. Issue src_a=1, src_b=2, both used -> rf_read_en_A/B=1 in cycle T only; op_valid at T+2 with op_a=0x11, op_b=0x22.
3. RAW: issue dst=3, wr=1, then issue src_a=3 -> iss_ready=0 until wb_valid, wb_addr=3, wb_data=0x5A. In that cycle the instruction is accepted and, 2 cycles later, op_a=0x5A (bypass, not stale rf data).
4. Backpressure: op_ready=0 for 5 cycles in VALID -> op_a/op_b/op_dst stable, iss_ready=0. Raise op_ready with the next instruction pending -> back-to-back accept, second op_valid 2 cycles later.
5. Unused sources and WAW: use_a=use_b=0 -> read enables stay 0, op_a=op_b=0. Issue dst=2, wr=1 twice -> second instruction stalls until wb to r2; set-wins when accept and wb to r2 coincide.
6. Reset asserted during READ -> next cycle op_valid=0, state IDLE, pending=0, rf_write_en=0 while in reset.
